serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built around one full-adder slice.
// The operation runs LSB first, one bit per clock, and takes exactly WIDTH
// cycles in RUN. DATA/CRR/ZERO are registered and change only when the FSM
// enters DONE.
// Optional feature macro: SERIAL_ADDER_SUB_EN. When it is defined, SUB=1
// selects A - B. When it is not defined, SUB is ignored and the block only adds.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] IN_Y,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             CIN,
    input  logic             SUB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DATA,
    output logic             CRR,
    output logic             ZERO
);

    // The counter only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;       // operand A, shifted right as bits are consumed
    logic [WIDTH-1:0] b_r;       // operand B, shifted right as bits are consumed
    logic [WIDTH-1:0] sum_r;     // partial result, filled from the MSB side
    logic [CW-1:0]    cnt_r;     // index of the bit being processed
    logic             carry_r;   // carry between successive slices
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] data_r;
    logic             crr_r;
    logic             zero_r;

    logic             b_bit_s;
    logic             sum_bit_s;
    logic             cout_s;
    logic [WIDTH-1:0] result_s;
    logic             seed_s;
    logic             unused_s;

`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_r;     // captured subtract select

    // Subtract is A + ~B + 1, so carry-out means "no borrow" (A >= B).
    assign seed_s   = SUB ? 1'b1 : CIN;
    assign unused_s = sum_r[0];
`else
    assign seed_s   = CIN;
    // SUB has no function in an add-only build.
    assign unused_s = sum_r[0] ^ SUB;
`endif

    // Single full-adder slice working on the current LSB of each operand.
    always_comb begin
        b_bit_s = b_r[0];
`ifdef SERIAL_ADDER_SUB_EN
        b_bit_s = b_r[0] ^ sub_r;
`endif
        sum_bit_s = a_r[0] ^ b_bit_s ^ carry_r;
        cout_s    = (a_r[0] & b_bit_s) | (a_r[0] & carry_r) | (b_bit_s & carry_r);
        // The new bit enters at the MSB. After WIDTH shifts it lands at bit 0.
        result_s  = {sum_bit_s, sum_r[WIDTH-1:1]};
    end

    // Control FSM, serial datapath and registered result outputs.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            crr_r   <= 1'b0;
            zero_r  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        a_r     <= IN_Y;
                        b_r     <= IN_DATA;
                        sum_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        carry_r <= seed_s;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_r   <= SUB;
`endif
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r   <= result_s;
                    carry_r <= cout_s;
                    if (cnt_r == LAST_BIT) begin
                        data_r  <= result_s;
                        crr_r   <= cout_s;
                        zero_r  <= (result_s == {WIDTH{1'b0}});
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign DATA = data_r;
    assign CRR  = crr_r;
    assign ZERO = zero_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder.
// It instantiates a WIDTH=4 copy and a WIDTH=8 copy and uses hand-computed
// expected values.
module tb_serial_adder;

    logic       CLK;
    logic       N_RESET;

    logic       start4, cin4, sub4;
    logic [3:0] y4, d4;
    logic       busy4, done4, crr4, zero4;
    logic [3:0] data4;

    logic       start8, cin8, sub8;
    logic [7:0] y8, d8;
    logic       busy8, done8, crr8, zero8;
    logic [7:0] data8;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(4)) dut4 (
        .CLK(CLK), .N_RESET(N_RESET), .START(start4), .IN_Y(y4), .IN_DATA(d4),
        .CIN(cin4), .SUB(sub4), .BUSY(busy4), .DONE(done4), .DATA(data4),
        .CRR(crr4), .ZERO(zero4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK(CLK), .N_RESET(N_RESET), .START(start8), .IN_Y(y8), .IN_DATA(d8),
        .CIN(cin8), .SUB(sub8), .BUSY(busy8), .DONE(done8), .DATA(data8),
        .CRR(crr8), .ZERO(zero8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, then check latency, the result and the single-cycle DONE pulse.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input logic [7:0] ed,
                          input logic ec, input logic ez, input string tag);
        int n;
        @(negedge CLK);
        if (w8) begin
            y8 = a; d8 = b; cin8 = ci; start8 = 1'b1;
        end else begin
            y4 = a[3:0]; d4 = b[3:0]; cin4 = ci; sub4 = sb; start4 = 1'b1;
        end
        @(negedge CLK);                      // cycle 1
        start4 = 1'b0;
        start8 = 1'b0;
        check({tag, "_busy1"}, w8 ? busy8 : busy4, 32'd1);
        n = 1;
        while (!(w8 ? done8 : done4) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_latency"}, n, w8 ? 32'd9 : 32'd5);
        check({tag, "_data"}, w8 ? data8 : {4'd0, data4}, ed);
        check({tag, "_crr"}, w8 ? crr8 : crr4, ec);
        check({tag, "_zero"}, w8 ? zero8 : zero4, ez);
        check({tag, "_busy_done"}, w8 ? busy8 : busy4, 32'd0);
        @(negedge CLK);
        check({tag, "_pulse_end"}, w8 ? done8 : done4, 32'd0);
    endtask

    initial begin
        int pulses;
        N_RESET = 1'b0;
        start4 = 1'b1; cin4 = 1'b0; sub4 = 1'b0; y4 = 4'd0; d4 = 4'd0;
        start8 = 1'b0; cin8 = 1'b0; sub8 = 1'b0; y8 = 8'd0; d8 = 8'd0;

        // Reset takes priority over a START that is held high.
        repeat (3) @(negedge CLK);
        check("rst_busy", busy4, 32'd0);
        check("rst_done", done4, 32'd0);
        check("rst_data", data4, 32'd0);
        check("rst_crr", crr4, 32'd0);
        check("rst_zero", zero4, 32'd0);
        check("rst_data8", data8, 32'd0);
        N_RESET = 1'b1;
        start4 = 1'b0;

        run_op(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1, "zero_add");
        run_op(1'b0, 8'h1, 8'h1, 1'b1, 1'b0, 8'h3, 1'b0, 1'b0, "one_one_cin");
        run_op(1'b0, 8'hF, 8'h1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, "wrap_zero");
        run_op(1'b0, 8'hA, 8'h6, 1'b1, 1'b0, 8'h1, 1'b1, 1'b0, "carry_out");
        run_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "w8_ff_01");

        // START held high across two back-to-back operations.
        // Operands that change during RUN must not be captured.
        @(negedge CLK);
        y4 = 4'b0001; d4 = 4'b0010; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
        @(negedge CLK);                      // cycle 1
        y4 = 4'b0100; d4 = 4'b0100;
        for (int n = 1; n <= 10; n++) begin
            check($sformatf("b2b_done_c%0d", n), done4, (n == 5 || n == 10) ? 32'd1 : 32'd0);
            if (n == 3) check("b2b_busy_c3", busy4, 32'd1);
            if (n == 5) check("b2b_data1", data4, 32'd3);
            if (n == 7) check("b2b_data_hold", data4, 32'd3);
            if (n == 10) begin
                check("b2b_data2", data4, 32'd8);
                start4 = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end

        // Reset in the second RUN cycle aborts the operation. No DONE pulse may follow.
        @(negedge CLK);
        y4 = 4'd3; d4 = 4'd3; start4 = 1'b1;
        @(negedge CLK);                      // cycle 1
        start4 = 1'b0;
        @(negedge CLK);                      // cycle 2
        N_RESET = 1'b0;
        @(negedge CLK);                      // cycle 3
        check("abort_busy", busy4, 32'd0);
        check("abort_data", data4, 32'd0);
        N_RESET = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge CLK);
            if (done4) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(1'b0, 8'h5, 8'h3, 1'b0, 1'b1, 8'h2, 1'b1, 1'b0, "sub_pos");
        run_op(1'b0, 8'h3, 8'h5, 1'b0, 1'b1, 8'hE, 1'b0, 1'b0, "sub_neg");
        run_op(1'b0, 8'h5, 8'h5, 1'b1, 1'b1, 8'h0, 1'b1, 1'b1, "sub_eq_cin_ign");
`else
        run_op(1'b0, 8'h5, 8'h3, 1'b0, 1'b1, 8'h8, 1'b0, 1'b0, "sub_ignored");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
